uart_rx_frame_ctrl: RTL and testbench

Receive-side frame controller that sits directly behind the UART receiver and turns its byte stream into validated command frames for the smartwatch core. It hunts for a start-of-frame byte, then captures length, command and payload, checks an XOR checksum, and enforces an inter-byte timeout. Accepted frames are held in an internal payload buffer until the consumer acknowledges them.

---
 rtl/uart_rx_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: SOF hunt, LEN/CMD/payload capture,
// XOR checksum check, inter-byte timeout, and a held payload buffer released by ack.
module uart_rx_frame_ctrl #(
  parameter int          MAX_PAYLOAD  = 16,
  parameter int          TIMEOUT_CLKS = 8680,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  localparam int         LW           = $clog2(MAX_PAYLOAD + 1),
  localparam int         AW           = $clog2(MAX_PAYLOAD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rx_dv,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_frame_ack,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_frame_valid,
  output logic [7:0]    o_cmd,
  output logic [LW-1:0] o_len,
  output logic          o_err_checksum,
  output logic          o_err_timeout,
  output logic          o_err_len,
  output logic          o_err_overrun
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {IDLE, GET_LEN, GET_CMD, GET_PAYLOAD, GET_CHK, HOLD} state_t;

  state_t        state;
  logic [7:0]    pay_buf [MAX_PAYLOAD];
  logic [LW-1:0] len_q;
  logic [7:0]    cmd_q;
  logic [7:0]    acc;
  logic [AW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic          last_payload;

  assign last_payload = (LW'(idx) + LW'(1)) == len_q;

  always_comb begin
    o_rd_data = '0;
    if (o_frame_valid && (LW'(i_rd_addr) < o_len))
      o_rd_data = pay_buf[i_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      cmd_q          <= '0;
      acc            <= '0;
      idx            <= '0;
      tcnt           <= '0;
      o_frame_valid  <= 1'b0;
      o_cmd          <= '0;
      o_len          <= '0;
      o_err_checksum <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_err_len      <= 1'b0;
      o_err_overrun  <= 1'b0;
      for (int unsigned i = 0; i < MAX_PAYLOAD; i++)
        pay_buf[i] <= '0;
    end else begin
      o_err_checksum <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_err_len      <= 1'b0;
      o_err_overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_dv && i_rx_byte == SOF_BYTE) begin
            state <= GET_LEN;
            tcnt  <= '0;
          end
        end
        GET_LEN, GET_CMD, GET_PAYLOAD, GET_CHK: begin
          if (i_rx_dv) begin
            tcnt <= '0;
            case (state)
              GET_LEN: begin
                if (32'(i_rx_byte) > MAX_PAYLOAD) begin
                  o_err_len <= 1'b1;
                  state     <= IDLE;
                end else begin
                  len_q <= LW'(i_rx_byte);
                  acc   <= i_rx_byte;
                  idx   <= '0;
                  state <= GET_CMD;
                end
              end
              GET_CMD: begin
                cmd_q <= i_rx_byte;
                acc   <= acc ^ i_rx_byte;
                state <= (len_q != '0) ? GET_PAYLOAD : GET_CHK;
              end
              GET_PAYLOAD: begin
                pay_buf[idx] <= i_rx_byte;
                acc          <= acc ^ i_rx_byte;
                idx          <= idx + 1'b1;
                if (last_payload)
                  state <= GET_CHK;
              end
              default: begin
                if (i_rx_byte == acc) begin
                  state         <= HOLD;
                  o_frame_valid <= 1'b1;
                  o_cmd         <= cmd_q;
                  o_len         <= len_q;
                end else begin
                  o_err_checksum <= 1'b1;
                  state          <= IDLE;
                end
              end
            endcase
          end else if (tcnt == TW'(TIMEOUT_CLKS - 1)) begin
            o_err_timeout <= 1'b1;
            tcnt          <= '0;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          // Bytes are dropped even in the ack cycle, so a SOF arriving then is lost.
          if (i_rx_dv)
            o_err_overrun <= 1'b1;
          if (i_frame_ack) begin
            o_frame_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed plan items plus random frames
// compared against a sequence-level frame classifier.
module tb_uart_rx_frame_ctrl;
  localparam int         MAXP = 16;
  localparam int         TO   = 8680;
  localparam logic [7:0] SOF  = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] cmd;
  logic [4:0] len;
  logic       err_checksum, err_timeout, err_len, err_overrun;

  int checks = 0;
  int failures = 0;
  int n_chk = 0, n_to = 0, n_len = 0, n_ovr = 0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CLKS(TO), .SOF_BYTE(SOF)) dut (
    .clk(clk), .rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte), .i_frame_ack(frame_ack),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_frame_valid(frame_valid), .o_cmd(cmd),
    .o_len(len), .o_err_checksum(err_checksum), .o_err_timeout(err_timeout),
    .o_err_len(err_len), .o_err_overrun(err_overrun)
  );

  // Count cycles each error flag is high; a pulse wider than one cycle counts twice.
  always @(posedge clk) begin
    #2;
    if (err_checksum) n_chk++;
    if (err_timeout)  n_to++;
    if (err_len)      n_len++;
    if (err_overrun)  n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is in the low clock phase; returns at the negedge after the capture edge.
  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic send_seq(input bq_t q, input int maxgap);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (maxgap > 0 && i != q.size() - 1) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  // Reference: classify a byte stream by the frame rules. kind 0=none 1=good 2=chk 3=len
  task automatic model(input bq_t q, output int kind, output logic [7:0] m_cmd,
                       output int m_len, output logic [7:0] m_pay[MAXP]);
    int i;
    logic [7:0] x;
    kind = 0; m_cmd = '0; m_len = 0; i = 0;
    for (int k = 0; k < MAXP; k++) m_pay[k] = '0;
    while (i < q.size() && q[i] != SOF) i++;
    if (i + 1 >= q.size()) return;
    m_len = int'(q[i+1]);
    if (m_len > MAXP) begin kind = 3; return; end
    m_cmd = q[i+2];
    x = q[i+1] ^ q[i+2];
    for (int k = 0; k < m_len; k++) begin
      m_pay[k] = q[i+3+k];
      x ^= q[i+3+k];
    end
    kind = (q[i+3+m_len] == x) ? 1 : 2;
  endtask

  task automatic check_held(input string tag, input logic [7:0] e_cmd, input int e_len,
                            input logic [7:0] e_pay[MAXP]);
    check({tag, "_valid"}, 32'(frame_valid), 32'd1);
    check({tag, "_cmd"}, 32'(cmd), 32'(e_cmd));
    check({tag, "_len"}, 32'(len), 32'(e_len));
    for (int a = 0; a < MAXP; a++) begin
      @(negedge clk);
      rd_addr = 4'(a);
      #1;
      check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), (a < e_len) ? 32'(e_pay[a]) : 32'd0);
    end
  endtask

  task automatic do_ack(input string tag);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(frame_valid), 32'd0);
    rd_addr = 4'($urandom_range(0, 15));
    #1;
    check({tag, "_ack_rd"}, 32'(rd_data), 32'd0);
  endtask

  // Send a stream, compare error deltas and held-frame contents with the model, then ack.
  task automatic run_frame(input string tag, input bq_t q, input int maxgap);
    int kind, m_len, c0, t0, l0, o0;
    logic [7:0] m_cmd;
    logic [7:0] m_pay[MAXP];
    model(q, kind, m_cmd, m_len, m_pay);
    c0 = n_chk; t0 = n_to; l0 = n_len; o0 = n_ovr;
    send_seq(q, maxgap);
    check({tag, "_err_chk"}, 32'(n_chk - c0), (kind == 2) ? 32'd1 : 32'd0);
    check({tag, "_err_len"}, 32'(n_len - l0), (kind == 3) ? 32'd1 : 32'd0);
    check({tag, "_err_to"}, 32'(n_to - t0), 32'd0);
    check({tag, "_err_ovr"}, 32'(n_ovr - o0), 32'd0);
    if (kind == 1) begin
      check_held(tag, m_cmd, m_len, m_pay);
      do_ack(tag);
    end else begin
      check({tag, "_novalid"}, 32'(frame_valid), 32'd0);
    end
  endtask

  initial begin : main
    bq_t good, q;
    logic [7:0] e_pay[MAXP];
    int o0, t0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_len", 32'(len), 32'd0);
    check("rst_errs", {28'd0, err_checksum, err_timeout, err_len, err_overrun}, 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ack while idle is ignored; good frame with latency check
    frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
    good = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h13};
    for (int k = 0; k < MAXP; k++) e_pay[k] = '0;
    e_pay[0] = 8'h11; e_pay[1] = 8'h22; e_pay[2] = 8'h33;
    for (int k = 0; k < 6; k++) send_byte(good[k]);
    check("good_pre_valid", 32'(frame_valid), 32'd0);
    send_byte(8'h13);
    check_held("good", 8'h10, 3, e_pay);
    do_ack("good");

    // Zero-length, checksum error, length error, garbage before SOF
    run_frame("zero", '{8'hA5, 8'h00, 8'h42, 8'h42}, 0);
    run_frame("badchk", '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h14}, 0);
    run_frame("badlen", '{8'hA5, 8'h11}, 0);
    run_frame("maxlen", '{8'hA5, 8'h10, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                          8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                          8'h0F, 8'h11}, 0);
    run_frame("garbage", '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h13}, 2);

    // Timeout: pulse exactly once after TO idle clocks following the last byte
    t0 = n_to;
    send_seq('{8'hA5, 8'h03, 8'h10, 8'h11}, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_early", 32'(n_to - t0), 32'd0);
    repeat (20) @(negedge clk);
    check("to_once", 32'(n_to - t0), 32'd1);
    check("to_novalid", 32'(frame_valid), 32'd0);
    run_frame("to_resync", good, 1);

    // Hold: three dropped bytes, then dv coincident with ack
    o0 = n_ovr;
    send_seq(good, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E);
    check("hold_ovr3", 32'(n_ovr - o0), 32'd3);
    check_held("hold", 8'h10, 3, e_pay);
    frame_ack = 1'b1; rx_dv = 1'b1; rx_byte = SOF;
    @(negedge clk);
    frame_ack = 1'b0; rx_dv = 1'b0;
    check("ackdv_valid", 32'(frame_valid), 32'd0);
    check("ackdv_ovr", 32'(n_ovr - o0), 32'd4);
    run_frame("after_ackdv", good, 0);

    // Random frames against the model
    for (int n = 0; n < 24; n++) begin
      int typ, plen;
      logic [7:0] x, b;
      q = {};
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == SOF) b = 8'h00;
        q.push_back(b);
      end
      typ = $urandom_range(0, 3);
      q.push_back(SOF);
      if (typ == 3) begin
        q.push_back(8'($urandom_range(MAXP + 1, 255)));
      end else begin
        plen = $urandom_range(0, MAXP);
        q.push_back(8'(plen));
        x = 8'(plen);
        b = 8'($urandom_range(0, 255));
        q.push_back(b); x ^= b;
        for (int k = 0; k < plen; k++) begin
          b = 8'($urandom_range(0, 255));
          q.push_back(b); x ^= b;
        end
        if (typ == 2) x ^= 8'($urandom_range(1, 255));
        q.push_back(x);
      end
      run_frame($sformatf("rnd%0d", n), q, 3);
    end

    // Asynchronous reset in GET_PAYLOAD (o_cmd still holds the last frame's command)
    send_seq('{8'hA5, 8'h03, 8'h10, 8'h11}, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(frame_valid), 32'd0);
    check("arst_cmd", 32'(cmd), 32'd0);
    check("arst_len", 32'(len), 32'd0);
    check("arst_errs", {28'd0, err_checksum, err_timeout, err_len, err_overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame("arst_after", good, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
